// File: rtl/btn_event_arbiter.sv
// Button front end: per-button synchroniser, rise detector and lockout debounce,
// feeding pending event bits that a round-robin arbiter hands out over valid/ready.
module btn_event_arbiter #(
    parameter  int NUM_BTN  = 2,
    parameter  int LOCK_CYC = 1000,
    localparam int ID_W     = $clog2(NUM_BTN),
    localparam int CNT_W    = $clog2(LOCK_CYC + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    input  logic               evt_ready,
    output logic [NUM_BTN-1:0] pending,
    output logic               overrun
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t             state_q, state_d;
    logic [NUM_BTN-1:0] s1_q, s2_q, s3_q;
    logic [NUM_BTN-1:0] rise, accept, clr;
    logic [CNT_W-1:0]   lock_q [NUM_BTN];
    logic [CNT_W-1:0]   lock_d [NUM_BTN];
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic               evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]    evt_id_q, evt_id_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    pick_hi, pick_lo, pick;
    logic               found_hi;
    logic               hs;

    // Sync flops reset to 1 so a button held through reset never looks like a rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
            s3_q <= '1;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            lock_d[i] = lock_q[i];
            if (lock_q[i] != '0) begin
                lock_d[i] = lock_q[i] - CNT_W'(1);
            end else if (rise[i]) begin
                accept[i] = 1'b1;
                lock_d[i] = CNT_W'(LOCK_CYC);
            end
        end
    end

    assign hs  = evt_valid_q & evt_ready;
    assign clr = hs ? (NUM_BTN'(1) << evt_id_q) : '0;

    // A fresh accept beats a same-cycle clear and is not an overrun.
    assign pending_d = (pending_q & ~clr) | accept;
    assign overrun_d = |(accept & pending_q & ~clr);

    // Round-robin: lowest set bit at or above rr, else lowest set bit below rr.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending_q[i] && (ID_W'(i) >= rr_q)) begin
                pick_hi  = ID_W'(i);
                found_hi = 1'b1;
            end
            if (pending_q[i] && (ID_W'(i) < rr_q)) begin
                pick_lo = ID_W'(i);
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_d        = rr_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    evt_id_d    = pick;
                    evt_valid_d = 1'b1;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    rr_d        = (evt_id_q == ID_W'(NUM_BTN - 1)) ? '0 : evt_id_q + ID_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                evt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            overrun_q   <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            rr_q        <= '0;
            for (int i = 0; i < NUM_BTN; i++) lock_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_q        <= rr_d;
            for (int i = 0; i < NUM_BTN; i++) lock_q[i] <= lock_d[i];
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: a cycle table for reset, latency and
// round-robin, then hand-written sequences for lockout, overrun and reset-in-offer.
module tb_btn_event_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn;
    logic       evt_valid;
    logic [0:0] evt_id;
    logic       evt_ready;
    logic [1:0] pending;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    btn_event_arbiter #(
        .NUM_BTN (2),
        .LOCK_CYC(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_ready(evt_ready),
        .pending  (pending),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [1:0] btn;
        logic       rdy;
        int         n;
        logic       v;
        logic [0:0] id;
        logic [1:0] pend;
        logic       ovr;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int nv;
        int no;
        int hs;

        // rst, btn, rdy, repeat, valid, id, pending, overrun (expected after each edge)
        tbl[0]  = '{1'b0, 2'b01, 1'b1,  2, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 2'b01, 1'b1, 20, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 2'b11, 1'b1,  2, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[3]  = '{1'b1, 2'b11, 1'b1,  1, 1'b0, 1'b0, 2'b10, 1'b0};
        tbl[4]  = '{1'b1, 2'b11, 1'b1,  1, 1'b1, 1'b1, 2'b10, 1'b0};
        tbl[5]  = '{1'b1, 2'b11, 1'b1,  1, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[6]  = '{1'b1, 2'b00, 1'b1, 10, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[7]  = '{1'b1, 2'b11, 1'b1,  2, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[8]  = '{1'b1, 2'b11, 1'b1,  1, 1'b0, 1'b0, 2'b11, 1'b0};
        tbl[9]  = '{1'b1, 2'b11, 1'b1,  1, 1'b1, 1'b0, 2'b11, 1'b0};
        tbl[10] = '{1'b1, 2'b11, 1'b1,  1, 1'b0, 1'b0, 2'b10, 1'b0};
        tbl[11] = '{1'b1, 2'b11, 1'b1,  1, 1'b1, 1'b1, 2'b10, 1'b0};
        tbl[12] = '{1'b1, 2'b11, 1'b1,  1, 1'b0, 1'b0, 2'b00, 1'b0};

        rst_n     = 1'b0;
        btn       = 2'b01;
        evt_ready = 1'b1;

        for (int j = 0; j < 13; j++) begin
            for (int r = 0; r < tbl[j].n; r++) begin
                rst_n     = tbl[j].rst_n;
                btn       = tbl[j].btn;
                evt_ready = tbl[j].rdy;
                tick();
                chk($sformatf("tbl%0d.%0d valid", j, r), 32'(evt_valid), 32'(tbl[j].v));
                chk($sformatf("tbl%0d.%0d pending", j, r), 32'(pending), 32'(tbl[j].pend));
                chk($sformatf("tbl%0d.%0d overrun", j, r), 32'(overrun), 32'(tbl[j].ovr));
                if (tbl[j].v) chk($sformatf("tbl%0d.%0d id", j, r), 32'(evt_id), 32'(tbl[j].id));
            end
        end

        // Lockout: btn[0] toggles every 2 cycles; only the first rise and the one after lockout count.
        btn = 2'b00;
        repeat (12) tick();
        nv = 0;
        no = 0;
        for (int c = 0; c < 28; c++) begin
            btn[0] = (c < 16) && ((c % 4) < 2);
            tick();
            nv += int'(evt_valid);
            no += int'(overrun);
        end
        chk("lockout events", 32'(nv), 32'd2);
        chk("lockout overrun", 32'(no), 32'd0);
        chk("lockout pending", 32'(pending), 32'd0);

        // Overrun: consumer stalled, second press after lockout lands on a set pending bit.
        btn       = 2'b00;
        evt_ready = 1'b0;
        repeat (12) tick();
        nv = 0;
        no = 0;
        for (int c = 0; c < 20; c++) begin
            btn[0] = (c == 0) || (c == 1) || (c == 10) || (c == 11);
            tick();
            no += int'(overrun);
            if (c >= 3) nv += int'(evt_valid && (evt_id == 1'b0));
        end
        chk("overrun pulses", 32'(no), 32'd1);
        chk("stall id0 stable", 32'(nv), 32'd17);
        chk("stall pending", 32'(pending), 32'd1);
        evt_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 6; c++) begin
            hs += int'(evt_valid && evt_ready);
            tick();
        end
        chk("stall handshakes", 32'(hs), 32'd1);
        chk("stall pending after", 32'(pending), 32'd0);

        // Reset while offering: offered event is lost, held button gives nothing new.
        btn       = 2'b00;
        evt_ready = 1'b0;
        repeat (4) tick();
        btn = 2'b10;
        repeat (4) tick();
        chk("offer valid", 32'(evt_valid), 32'd1);
        chk("offer id", 32'(evt_id), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rst valid", 32'(evt_valid), 32'd0);
        chk("rst pending", 32'(pending), 32'd0);
        chk("rst id", 32'(evt_id), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            nv += int'(evt_valid);
        end
        chk("post-rst events", 32'(nv), 32'd0);
        chk("post-rst pending", 32'(pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
